// File: rtl/move_arbiter_if.sv
// Move-request / board-write bundle between the move sources,
// the arbiter (slave) and the game controller side (master).
interface move_arbiter_if;
  logic        turnIsHuman;
  logic        gameIsDone;
  logic [17:0] gBoard;
  logic        humanReq;
  logic [3:0]  humanCell;
  logic        aiReq;
  logic [3:0]  aiCell;
  logic        playerWrite;
  logic [3:0]  playerInput;
  logic        humanAck;
  logic        aiAck;
  logic        illegalMove;
  logic        timeoutMove;
  logic        busy;

  modport master (
    output turnIsHuman, gameIsDone, gBoard,
    output humanReq, humanCell, aiReq, aiCell,
    input  playerWrite, playerInput,
    input  humanAck, aiAck, illegalMove,
    input  timeoutMove, busy
  );

  modport slave (
    input  turnIsHuman, gameIsDone, gBoard,
    input  humanReq, humanCell, aiReq, aiCell,
    output playerWrite, playerInput,
    output humanAck, aiAck, illegalMove,
    output timeoutMove, busy
  );
endinterface

// File: rtl/move_arbiter.sv
// Grants the on-turn move source, legality-checks it against gBoard and
// issues a one-cycle board write. Optional auto-move: MOVE_TIMEOUT_EN.
module move_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic           ph1,
  input logic           ph2,
  input logic           reset,
  move_arbiter_if.slave mv
);
  typedef enum logic [2:0] {
    IDLE, CHECK, WRITE, SETTLE, REJECT
  } state_e;

  typedef enum logic [1:0] {
    SRC_HUMAN, SRC_AI, SRC_TIMEOUT
  } src_e;

  state_e     state_q, state_d;
  src_e       src_q, src_d;
  logic [3:0] cell_q, cell_d;
  logic       armed_q, armed_d;

  logic       pw_q, pw_d;
  logic [3:0] pi_q, pi_d;
  logic       ha_q, ha_d;
  logic       aa_q, aa_d;
  logic       il_q, il_d;
  logic       busy_q, busy_d;

  logic [1:0] cell_st;
  logic       legal;
  logic       human_go;
  logic       ai_go;
  logic       tmo_go;
  logic [3:0] tmo_cell;
  logic       unused_ph2;

  // ph1 rising is the capture point of the two-phase flop pair
  assign unused_ph2 = ph2;

  assign cell_st  = 2'(mv.gBoard >> {cell_q, 1'b0});
  assign legal    = (cell_q <= 4'd8) && (cell_st == 2'b00);
  assign human_go = mv.turnIsHuman && mv.humanReq && armed_q;
  assign ai_go    = !mv.turnIsHuman && mv.aiReq;

`ifdef MOVE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          any_empty;
  logic          to_q, to_d;

  always_comb begin
    tmo_cell  = 4'hF;
    any_empty = 1'b0;
    for (int n = 8; n >= 0; n--) begin
      if (mv.gBoard[2*n +: 2] == 2'b00) begin
        tmo_cell  = 4'(n);
        any_empty = 1'b1;
      end
    end
  end

  assign tmo_go = any_empty &&
    (tcnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tcnt_d = '0;
    if (state_q == IDLE && mv.turnIsHuman &&
        !mv.gameIsDone)
      tcnt_d = tcnt_q + CW'(1);
  end

  always_comb begin
    to_d = (state_d == WRITE) &&
           (src_q == SRC_TIMEOUT);
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      tcnt_q <= '0;
      to_q   <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      to_q   <= to_d;
    end
  end

  assign mv.timeoutMove = to_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign tmo_go         = 1'b0;
  assign tmo_cell       = 4'hF;
  assign mv.timeoutMove = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cell_d  = cell_q;
    unique case (state_q)
      IDLE: begin
        if (!mv.gameIsDone) begin
          if (human_go) begin
            cell_d  = mv.humanCell;
            src_d   = SRC_HUMAN;
            state_d = CHECK;
          end else if (ai_go) begin
            cell_d  = mv.aiCell;
            src_d   = SRC_AI;
            state_d = CHECK;
          end else if (mv.turnIsHuman && tmo_go) begin
            cell_d  = tmo_cell;
            src_d   = SRC_TIMEOUT;
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (mv.gameIsDone) state_d = IDLE;
        else if (legal)    state_d = WRITE;
        else               state_d = REJECT;
      end
      WRITE:   state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      REJECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // a held key yields one move; release re-arms
  always_comb begin
    armed_d = armed_q;
    if (!mv.humanReq)
      armed_d = 1'b1;
    else if (state_q == IDLE && !mv.gameIsDone && human_go)
      armed_d = 1'b0;
  end

  always_comb begin
    pw_d   = (state_d == WRITE);
    pi_d   = pw_d ? cell_q : 4'hF;
    ha_d   = pw_d && (src_q == SRC_HUMAN);
    aa_d   = pw_d && (src_q == SRC_AI);
    il_d   = (state_d == REJECT);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= SRC_HUMAN;
      cell_q  <= 4'hF;
      armed_q <= 1'b0;
      pw_q    <= 1'b0;
      pi_q    <= 4'hF;
      ha_q    <= 1'b0;
      aa_q    <= 1'b0;
      il_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cell_q  <= cell_d;
      armed_q <= armed_d;
      pw_q    <= pw_d;
      pi_q    <= pi_d;
      ha_q    <= ha_d;
      aa_q    <= aa_d;
      il_q    <= il_d;
      busy_q  <= busy_d;
    end
  end

  assign mv.playerWrite = pw_q;
  assign mv.playerInput = pi_q;
  assign mv.humanAck    = ha_q;
  assign mv.aiAck       = aa_q;
  assign mv.illegalMove = il_q;
  assign mv.busy        = busy_q;
endmodule

// File: tb/tb_move_arbiter.sv
// Directed + random bench for move_arbiter against a
// cycle-count transaction model of the move protocol.
module tb_move_arbiter;
  localparam int T = 8;

  logic ph1, ph2, reset;
  move_arbiter_if bus();

  move_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .ph1  (ph1),
    .ph2  (ph2),
    .reset(reset),
    .mv   (bus)
  );

  initial begin
    ph1 = 0;
    ph2 = 0;
    forever begin
      #2 ph1 = 1;
      #3 ph1 = 0;
      #2 ph2 = 1;
      #3 ph2 = 0;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int idle_from = 0;
  int chk_cyc = -1;
  int tcnt = 0;
  int m_src = 0;
  int writes = 0;
  int hacks = 0;
  int seen = 0;
  bit m_armed = 0;
  logic [3:0] m_cell = 0;
  logic e_pw, e_ha, e_aa, e_il, e_to, e_busy;
  logic [3:0] e_pi;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic int first_empty(logic [17:0] b);
    for (int n = 0; n < 9; n++)
      if (b[2*n +: 2] == 2'b00) return n;
    return -1;
  endfunction

  task automatic accept(input int src, input logic [3:0] c);
    m_src     = src;
    m_cell    = c;
    chk_cyc   = cyc + 1;
    idle_from = cyc + 1000000;
  endtask

  // predict next-cycle outputs from this cycle's inputs, step, compare
  task automatic tick();
    bit idle;
    bit acc_h;
    int fe;
    idle  = (cyc >= idle_from);
    acc_h = 0;
    {e_pw, e_ha, e_aa, e_il, e_to} = '0;
    e_pi = 4'hF;
    if (reset) begin
      idle_from = cyc + 1;
      chk_cyc   = -1;
      m_armed   = 0;
      tcnt      = 0;
    end else begin
      if (cyc == chk_cyc) begin
        chk_cyc = -1;
        if (bus.gameIsDone) begin
          idle_from = cyc + 1;
        end else if (m_cell <= 8 &&
                     bus.gBoard[2*m_cell +: 2] == 2'b00) begin
          e_pw = 1;
          e_pi = m_cell;
          e_ha = (m_src == 0);
          e_aa = (m_src == 1);
          e_to = (m_src == 2);
          idle_from = cyc + 3;
        end else begin
          e_il = 1;
          idle_from = cyc + 2;
        end
      end else if (idle && !bus.gameIsDone) begin
        fe = first_empty(bus.gBoard);
        if (bus.turnIsHuman && bus.humanReq && m_armed) begin
          acc_h = 1;
          accept(0, bus.humanCell);
        end else if (!bus.turnIsHuman && bus.aiReq) begin
          accept(1, bus.aiCell);
        end
`ifdef MOVE_TIMEOUT_EN
        else if (bus.turnIsHuman && tcnt == T - 1 && fe >= 0)
          accept(2, 4'(fe));
`endif
      end
      tcnt = (idle && bus.turnIsHuman && !bus.gameIsDone) ?
             (tcnt + 1) % T : 0;
      if (!bus.humanReq) m_armed = 1;
      else if (acc_h)    m_armed = 0;
    end
    e_busy = ((cyc + 1) < idle_from);
    @(posedge ph1);
    #1;
    cyc++;
    if (bus.playerWrite === 1'b1) writes++;
    if (bus.humanAck === 1'b1) hacks++;
    chk("playerWrite", bus.playerWrite, e_pw);
    chk("playerInput", bus.playerInput, e_pi);
    chk("humanAck", bus.humanAck, e_ha);
    chk("aiAck", bus.aiAck, e_aa);
    chk("illegalMove", bus.illegalMove, e_il);
    chk("timeoutMove", bus.timeoutMove, e_to);
    chk("busy", bus.busy, e_busy);
  endtask

  initial begin
    reset = 1;
    bus.turnIsHuman = 1;
    bus.gameIsDone = 0;
    bus.gBoard = '0;
    bus.humanReq = 0;
    bus.humanCell = 0;
    bus.aiReq = 0;
    bus.aiCell = 0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_pi", bus.playerInput, 4'hF);
    chk("rst_pw", bus.playerWrite, 0);
    reset = 0;
    tick();
    tick();

    // human move to cell 4, key held
    bus.humanReq = 1;
    bus.humanCell = 4;
    hacks = 0;
    tick();
    chk("h_busy_k1", bus.busy, 1);
    chk("h_pw_k1", bus.playerWrite, 0);
    tick();
    chk("h_pw_k2", bus.playerWrite, 1);
    chk("h_pi_k2", bus.playerInput, 4);
    chk("h_ack_k2", bus.humanAck, 1);
    tick();
    chk("h_pw_k3", bus.playerWrite, 0);
    chk("h_busy_k3", bus.busy, 1);
    tick();
    chk("h_busy_k4", bus.busy, 0);
    repeat (16) tick();
    chk("h_single", hacks, 1);

    // AI onto occupied cell 4, then retry cell 0
    bus.humanReq = 0;
    bus.turnIsHuman = 0;
    bus.gBoard = 18'h00300;
    bus.aiReq = 1;
    bus.aiCell = 4;
    writes = 0;
    tick();
    bus.aiCell = 0;
    tick();
    chk("ai_ill", bus.illegalMove, 1);
    chk("ai_ill_pw", bus.playerWrite, 0);
    tick();
    chk("ai_idle", bus.busy, 0);
    tick();
    tick();
    chk("ai_pw", bus.playerWrite, 1);
    chk("ai_pi", bus.playerInput, 0);
    chk("ai_ack", bus.aiAck, 1);
    bus.aiReq = 0;
    repeat (3) tick();
    chk("ai_writes", writes, 1);

    // human out-of-range cell; AI request off-turn
    bus.turnIsHuman = 1;
    bus.aiReq = 1;
    bus.aiCell = 1;
    writes = 0;
    tick();
    bus.humanReq = 1;
    bus.humanCell = 4'd12;
    tick();
    tick();
    chk("h12_ill", bus.illegalMove, 1);
    chk("h12_pw", bus.playerWrite, 0);
    repeat (3) tick();
    chk("h12_nowrite", writes, 0);
    bus.humanReq = 0;
    bus.aiReq = 0;
    tick();

    // reset in CHECK with key held through it
    bus.humanReq = 1;
    bus.humanCell = 5;
    tick();
    chk("rc_busy_pre", bus.busy, 1);
    reset = 1;
    tick();
    chk("rc_busy", bus.busy, 0);
    chk("rc_pi", bus.playerInput, 4'hF);
    chk("rc_pw", bus.playerWrite, 0);
    reset = 0;
    hacks = 0;
    repeat (6) tick();
    chk("rc_held", hacks, 0);
    bus.humanReq = 0;
    tick();
    bus.humanReq = 1;
    tick();
    tick();
    chk("rc_pw2", bus.playerWrite, 1);
    chk("rc_pi2", bus.playerInput, 5);
    bus.humanReq = 0;
    repeat (3) tick();

    // game over: nothing is written
    bus.gameIsDone = 1;
    bus.aiReq = 1;
    bus.humanReq = 1;
    writes = 0;
    repeat (5) tick();
    bus.humanReq = 0;
    tick();
    bus.humanReq = 1;
    bus.turnIsHuman = 0;
    repeat (12) tick();
    chk("done_nowrite", writes, 0);
    bus.gameIsDone = 0;
    bus.aiReq = 0;
    bus.humanReq = 0;

    // idle human turn, cells 0-2 taken
    bus.turnIsHuman = 1;
    bus.gBoard = 18'h0003F;
    writes = 0;
    hacks = 0;
    seen = 0;
    repeat (12) begin
      tick();
      if (bus.playerWrite === 1'b1 && bus.playerInput === 4'd3 &&
          bus.timeoutMove === 1'b1)
        seen++;
    end
`ifdef MOVE_TIMEOUT_EN
    chk("to_write", seen, 1);
    chk("to_nohack", hacks, 0);
`else
    chk("no_to_write", writes, 0);
`endif

    // random traffic
    repeat (800) begin
      reset = ($urandom_range(0, 99) < 2);
      bus.gameIsDone = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 9) == 0)
        bus.turnIsHuman = ~bus.turnIsHuman;
      if ($urandom_range(0, 3) == 0)
        bus.humanReq = ~bus.humanReq;
      bus.humanCell = 4'($urandom_range(0, 10));
      bus.aiReq = ($urandom_range(0, 1) == 1);
      bus.aiCell = 4'($urandom_range(0, 10));
      if ($urandom_range(0, 3) == 0)
        for (int n = 0; n < 9; n++)
          bus.gBoard[2*n +: 2] = ($urandom_range(0, 9) < 6) ?
            2'b00 : 2'($urandom_range(1, 3));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/move_arbiter.md
# move_arbiter

Sequences board writes for the tic-tac-toe game, sitting between the move sources and the game controller FSM. It accepts move requests from the human keypad and the AI move engine and grants the one matching the current turn. It checks each move against the current board and issues a single-cycle write strobe with the cell address. Illegal moves are rejected with a flag and no write.

## Interface
- `TIMEOUT_CYCLES`, default 1024: human-turn idle cycles before an automatic move (used only with `MOVE_TIMEOUT_EN`); must be ≥2.
- `ph1`, `ph2`, input, 1 bit each: two non-overlapping phases of the single system clock. All registers use the team two-phase flop; one cycle is one ph1/ph2 pair.
- `reset`, input, 1: synchronous, active-high.
- `turnIsHuman`, input, 1: high while the controller is in PLAYER1 (human plays O).
- `gameIsDone`, input, 1: game over; no further writes.
- `gBoard`, input, 18: board state; cell n (0–8) is at `gBoard[2n+1:2n]`; 00 means empty.
- `humanReq`, input, 1: keypad press (level).
- `humanCell`, input, 4: keypad cell index.
- `aiReq`, input, 1: AI move request (level, held until ack).
- `aiCell`, input, 4: AI cell index.
- `playerWrite`, output, 1: one-cycle write strobe to the controller.
- `playerInput`, output, 4: cell address. Equals 4'b1111 whenever `playerWrite` is 0.
- `humanAck`, output, 1: one-cycle pulse, human move written.
- `aiAck`, output, 1: one-cycle pulse, AI move written.
- `illegalMove`, output, 1: one-cycle pulse, request rejected.
- `timeoutMove`, output, 1: one-cycle pulse, automatic move written.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- States: IDLE, CHECK, WRITE, SETTLE, REJECT. All outputs are registered (Moore).
- IDLE:
  - If `gameIsDone`, stay in IDLE.
  - Else if `turnIsHuman`, `humanReq` and `armed`: latch `humanCell`, source=HUMAN, clear `armed`, go to CHECK.
  - Else if `!turnIsHuman` and `aiReq`: latch `aiCell`, source=AI, go to CHECK.
  - Requests from the off-turn source are ignored and get no response.
- `armed` is set in any cycle where `humanReq` is 0. A held key therefore produces exactly one move; the key must be released before the next move.
- CHECK:
  - If `gameIsDone`, go to IDLE with no write.
  - Legal means the latched cell is ≤8 and `gBoard` at that cell is 00.
  - Legal goes to WRITE; illegal goes to REJECT.
- WRITE: `playerWrite`=1 and `playerInput`=latched cell for one cycle. The ack matching the source pulses in the same cycle. Next state is SETTLE.
- SETTLE: one dead cycle so the controller state and `gBoard` can update. Next state is IDLE.
- REJECT: `illegalMove`=1 for one cycle, then IDLE. The AI may retry from the next IDLE cycle; the human must release and press again.
- Reset, including mid-operation: state=IDLE, `armed`=0, timeout counter=0. Outputs become `playerWrite`=0, `playerInput`=4'b1111, and all pulses and `busy` at 0. Reset takes priority over every transition.

## Timing
- Request sampled in IDLE at cycle k:
  - `busy` goes high at k+1 (CHECK).
  - `playerWrite` and the ack are high at k+2 only.
  - SETTLE is at k+3; IDLE resumes at k+4.
  - Minimum spacing between writes is 4 cycles.
- Illegal request: `illegalMove` pulses at k+2 and IDLE resumes at k+3.
- `gBoard` is sampled in CHECK, so a board change in the same cycle as the request is honoured.
- `turnIsHuman` changing while `busy` does not abort an accepted move.
- `gameIsDone` rising in WRITE does not cancel the strobe already issued.

## Configuration
- `MOVE_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES) increments each cycle in IDLE with `turnIsHuman` high and `gameIsDone` low; otherwise it clears.
  - In the IDLE cycle where it reaches TIMEOUT_CYCLES−1 with no human request, the block latches the lowest-index empty cell from `gBoard`, sets source=TIMEOUT and goes to CHECK.
  - In WRITE, `timeoutMove` pulses and `humanAck` stays 0.
  - A human request in that same cycle wins.
  - If there is no empty cell, no action is taken.
- `MOVE_TIMEOUT_EN` undefined: no counter is built, `timeoutMove` is tied to 0, and `TIMEOUT_CYCLES` is ignored.

## Test plan
- Empty board, `turnIsHuman`=1, `humanReq`=1 and `humanCell`=4 at cycle k → `playerWrite`=1, `playerInput`=4 and `humanAck`=1 at k+2 only. Holding `humanReq` for 20 cycles produces no second write.
- `gBoard`=18'h00300 (cell 4 is O), AI turn, `aiCell`=4 → `illegalMove` at k+2, no write. `aiCell` changed to 0 → write to address 0 and `aiAck` at 2 cycles after the retry is sampled.
- `humanCell`=4'd12 → `illegalMove`, no write. `aiReq`=1 during the human turn → ignored, no ack.
- Assert `reset` in the CHECK cycle → next cycle `busy`=0, `playerInput`=4'b1111, no strobe. With `humanReq` held through reset, no move is made until the key is released and pressed again.
- `gameIsDone`=1 with requests pending → `playerWrite` stays 0 indefinitely.
- With `MOVE_TIMEOUT_EN`, TIMEOUT_CYCLES=8, cells 0–2 full, human turn idle → 8 cycles later `playerInput`=3 and `timeoutMove`=1. Without the macro → no write.
